mult4s_shared_arbiter: RTL and testbench

//   Shares one registered signed OP_W x OP_W multiplier among NUM_REQ requesters.
//   - Per-requester valid/ready request ports and valid/ready response ports.
//   - Round-robin arbitration, at most one issue per cycle.
//   - Tracks in-flight operations with a LATENCY-deep tag pipeline.
//   - Captures each product into the owning requester's result slot.

---
 rtl/mult4s_shared_arbiter.sv | 133 +++++++++++++
 tb/tb_mult4s_shared_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult4s_shared_arbiter.sv
// Round-robin front end sharing one registered signed multiplier among NUM_REQ clients.
// Issue to result: LATENCY+1 edges. A client is blocked while its previous result is unconsumed.
module mult4s_shared_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 4,
  parameter int LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OP_W-1:0]     req_a,
  input  logic [NUM_REQ*OP_W-1:0]     req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [NUM_REQ*2*OP_W-1:0]   rsp_product,
  output logic [OP_W-1:0]             mul_a,
  output logic [OP_W-1:0]             mul_b,
  input  logic [2*OP_W-1:0]           mul_p,
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW    = 2 * OP_W;

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic               issue;
  logic [LATENCY-1:0] tag_vld;
  logic [IDX_W-1:0]   tag_idx [LATENCY];
  logic [PW-1:0]      slot    [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_hs;

  // Gating with rst_n keeps req_ready and the operand bus at zero during reset.
  assign elig   = req_valid & ~pending & {NUM_REQ{rst_n}};
  assign rsp_hs = rsp_valid & rsp_ready;

  always_comb begin : arb
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    grant = '0;
    gidx  = '0;
    sum   = '0;
    cand  = '0;
    // Walk from the farthest candidate back to ptr so the nearest eligible wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (elig[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  assign issue     = |grant;
  assign req_ready = grant;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (issue) begin
      mul_a = req_a[int'(gidx)*OP_W +: OP_W];
      mul_b = req_b[int'(gidx)*OP_W +: OP_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      pending <= '0;
    end else begin
      if (issue) begin
        if (gidx == IDX_W'(NUM_REQ - 1)) begin
          ptr <= '0;
        end else begin
          ptr <= gidx + IDX_W'(1);
        end
      end
      pending <= (pending | grant) & ~rsp_hs;
    end
  end

  // Tag pipeline mirrors the multiplier's depth so the owner is known when mul_p is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_idx[k] <= '0;
      end
    end else begin
      tag_vld[0] <= issue;
      tag_idx[0] <= gidx;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_vld[LATENCY-1] && (tag_idx[LATENCY-1] == IDX_W'(i))) begin
          rsp_valid[i] <= 1'b1;
          slot[i]      <= mul_p;
        end else if (rsp_hs[i]) begin
          rsp_valid[i] <= 1'b0;
          slot[i]      <= '0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign rsp_product[i*PW +: PW] = slot[i];
  end

  assign busy = (|tag_vld) | (|rsp_valid);

endmodule

// File: tb/tb_mult4s_shared_arbiter.sv
// Bench for mult4s_shared_arbiter: directed cases plus random stress, scoreboarded
// against a round-robin / a*b reference model, with a behavioural multiplier attached.
module tb_mult4s_shared_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int L  = 2;
  localparam int AW = N * W;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [AW-1:0] req_a;
  logic [AW-1:0] req_b;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [N*PW-1:0] rsp_product;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [PW-1:0] mul_p;
  logic          busy;

  mult4s_shared_arbiter #(.NUM_REQ(N), .OP_W(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural registered multiplier: operands sampled at edge T, product visible after T+L-1.
  logic signed [PW-1:0] mul_full;
  logic [PW-1:0] p_pipe [L];
  assign mul_full = $signed(mul_a) * $signed(mul_b);
  assign mul_p    = p_pipe[L-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) p_pipe[k] <= '0;
    end else begin
      p_pipe[0] <= mul_full;
      for (int k = 1; k < L; k++) p_pipe[k] <= p_pipe[k-1];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return PW'(sa * sb);
  endfunction

  typedef struct {
    logic [PW-1:0] prod;
    int            due;
  } exp_t;

  // Per-requester outstanding ops; a non-empty queue means that requester is pending.
  exp_t exp_q [N][$];
  int   last_g = N - 1;
  int   grant_cnt [N];
  int   glog [$];
  int   gcyc [$];

  logic         iss_any;
  logic         iss_found;
  logic [N-1:0] iss_g;
  logic [W-1:0] iss_a, iss_b;
  int           iss_idx;
  exp_t         iss_e;

  initial for (int i = 0; i < N; i++) grant_cnt[i] = 0;

  // Issue side: predicts grant/operands from the round-robin rule, pushes expected results.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_g = N - 1;
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      iss_any = 1'b0;
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) iss_any = 1'b1;
      check("busy", busy, iss_any);
      iss_g = '0; iss_a = '0; iss_b = '0; iss_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        iss_idx = (last_g + k) % N;
        if (!iss_found && req_valid[iss_idx] && exp_q[iss_idx].size() == 0) begin
          iss_found = 1'b1;
          iss_g[iss_idx] = 1'b1;
          iss_a = req_a[iss_idx*W +: W];
          iss_b = req_b[iss_idx*W +: W];
        end
      end
      check("grant", req_ready, iss_g);
      check("mul_a", mul_a, iss_a);
      check("mul_b", mul_b, iss_b);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          iss_e.prod = ref_mul(req_a[i*W +: W], req_b[i*W +: W]);
          iss_e.due  = cyc + L + 1;
          exp_q[i].push_back(iss_e);
          last_g = i;
          grant_cnt[i]++;
          glog.push_back(i);
          gcyc.push_back(cyc);
        end
      end
    end
  end

  // Response monitor: checks arrival time, product, and absence of spurious responses.
  logic [N-1:0] prev_v = '0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_v = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && !prev_v[i]) begin
          if (exp_q[i].size() == 0) check("spurious_rsp", rsp_valid[i], 1'b0);
          else check("rsp_time", cyc, exp_q[i][0].due);
        end
        if (rsp_valid[i] && rsp_ready[i] && exp_q[i].size() != 0) begin
          check("rsp_product", rsp_product[i*PW +: PW], exp_q[i][0].prod);
          void'(exp_q[i].pop_front());
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic drain();
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("drain_busy", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_rsp_valid"}, rsp_valid, '0);
    check({tag, "_rsp_product"}, rsp_product, '0);
    check({tag, "_mul_a"}, mul_a, '0);
    check({tag, "_mul_b"}, mul_b, '0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  int c0 [N];
  logic [7:0] corner [N];

  initial begin
    // All requesters valid out of reset: r0..r3 on consecutive cycles
    rst_n = 1'b0; req_valid = '1; rsp_ready = '1;
    req_a = AW'($urandom); req_b = AW'($urandom);
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rr_count", glog.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k < glog.size()) begin
        check("rr_order", glog[k], k);
        check("rr_consecutive", gcyc[k], gcyc[0] + k);
      end
    end
    drain();

    // Single op on r0: 3 * -2, result held until consumed
    @(posedge clk); #1;
    req_valid = 4'b0001; req_a[3:0] = 4'd3; req_b[3:0] = 4'hE; rsp_ready = 4'b1110;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[0]) break;
    end
    check("single_grant", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    check("single_valid", rsp_valid[0], 1'b1);
    check("single_product", rsp_product[7:0], 8'hFA);
    repeat (3) @(negedge clk);
    check("single_hold_valid", rsp_valid[0], 1'b1);
    check("single_hold_product", rsp_product[7:0], 8'hFA);
    drain();

    // Corner operands, one per index
    @(posedge clk); #1;
    req_a = {4'h0, 4'hF, 4'h7, 4'h8};
    req_b = {4'h5, 4'hF, 4'h8, 4'h8};
    corner[0] = 8'h40; corner[1] = 8'hC8; corner[2] = 8'h01; corner[3] = 8'h00;
    req_valid = '1; rsp_ready = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid == '1) break;
    end
    check("corner_valid", rsp_valid, 4'hF);
    for (int i = 0; i < N; i++) check("corner_product", rsp_product[i*PW +: PW], corner[i]);
    drain();

    // r1 withholds rsp_ready: it must not be re-granted while r0/r2 keep cycling
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) c0[i] = grant_cnt[i];
    req_valid = 4'b0111; rsp_ready = 4'b1101;
    req_a = AW'($urandom); req_b = AW'($urandom);
    repeat (20) @(posedge clk);
    #1;
    check("starve_r1_grants", grant_cnt[1] - c0[1], 1);
    check("starve_r0_cycles", (grant_cnt[0] - c0[0]) >= 4, 1'b1);
    check("starve_r2_cycles", (grant_cnt[2] - c0[2]) >= 4, 1'b1);
    rsp_ready = '1;
    repeat (10) @(posedge clk);
    drain();

    // Reset with two ops in flight
    @(posedge clk); #1;
    req_valid = 4'b0011;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    req_valid = '1; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_grant", req_ready, 4'b0001);
    repeat (10) @(posedge clk);
    drain();

    // Random stress with response backpressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      req_a = AW'($urandom);
      req_b = AW'($urandom);
    end
    drain();
    for (int i = 0; i < N; i++) check("leftover_ops", exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
